// File: rtl/ptx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptx_pkg
// Description : Shared types and constants for the ptx_serializer lane
//               transmitter: FSM state encoding, default comma byte and the
//               bit-position counter width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ptx_pkg;

  // Transmitter state: commas during SYNC, data or idle commas in ACTIVE.
  typedef enum logic [0:0] {
    PTX_SYNC   = 1'b0,
    PTX_ACTIVE = 1'b1
  } ptx_state_e;

  // Idle / framing byte the receiver locks onto.
  localparam logic [7:0] c_COMMA_DEFAULT = 8'hBC;

  // Width of the bit-position counter (eight bit times per byte).
  localparam int c_BIT_CNT_W = 3;

endpackage : ptx_pkg
`default_nettype wire

// File: rtl/ptx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ptx_shifter
// Description : 8-bit load/shift register with a registered serial output.
//               On a load cycle the MSB of the new byte goes straight to the
//               output flop and the remaining seven bits are parked in the
//               shift register, so bytes run back-to-back with no gap bit.
// Ports       : clk_i   - bit clock
//               rst_ni  - asynchronous active-low reset
//               load_i  - take byte_i on this edge
//               byte_i  - parallel byte to serialise
//               data_o  - serial bit, MSB first, registered
// Revision    : 1.0 - initial release
// ============================================================================
module ptx_shifter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       data_o
);

  logic [7:0] shreg_q;
  logic [7:0] shreg_d;
  logic       data_q;
  logic       data_d;

  always_comb begin
    if (load_i) begin
      data_d  = byte_i[7];
      shreg_d = {byte_i[6:0], 1'b0};
    end else begin
      data_d  = shreg_q[7];
      shreg_d = {shreg_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= 8'h00;
      data_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : ptx_shifter
`default_nettype wire

// File: rtl/ptx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ptx_serializer
// Description : Parallel-to-serial lane transmitter. Loads one byte every
//               eight clk_32f cycles and shifts it out MSB first. After reset
//               a fixed run of SYNC_BYTES commas is sent so the far end can
//               frame; afterwards valid bytes are sent and commas fill idle
//               slots.
// Ports       : clk_32f    - bit clock
//               reset      - asynchronous active-low reset
//               data_p     - parallel byte to transmit
//               valid_p    - data_p valid, sampled on load edges only
//               byte_req   - high in the cycle whose closing edge samples data
//               data_out   - serial bit, registered
//               tx_active  - sync run complete
//               byte_count - valid bytes sent (only with PTX_COUNT_EN)
// Build macro : PTX_COUNT_EN enables the byte_count port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ptx_serializer
  import ptx_pkg::*;
#(
  parameter int         SYNC_BYTES = 4,
  parameter logic [7:0] COMMA      = c_COMMA_DEFAULT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_p,
  input  logic        valid_p,
  output logic        byte_req,
  output logic        data_out,
`ifdef PTX_COUNT_EN
  output logic [15:0] byte_count,
`endif
  output logic        tx_active
);

  localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST = '1;
  localparam logic [c_BIT_CNT_W-1:0] c_BIT_ONE  = {{(c_BIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]             c_SYNC_LAST = 4'(SYNC_BYTES);

  ptx_state_e               state_q;
  ptx_state_e               state_d;
  logic [c_BIT_CNT_W-1:0]   bit_cnt_q;
  logic [3:0]               sync_cnt_q;
  logic [3:0]               sync_cnt_d;
  logic [7:0]               w_load_byte;
  logic                     w_load;

  // bit_cnt resets to its last value so the first edge after reset is a load.
  assign w_load = (bit_cnt_q == c_BIT_LAST);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= PTX_SYNC;
      bit_cnt_q  <= c_BIT_LAST;
      sync_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_q + c_BIT_ONE;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    w_load_byte = COMMA;
    case (state_q)
      PTX_SYNC: begin
        // Input is ignored while syncing; the comma that brings the count up
        // to SYNC_BYTES is the last one, and its load edge enters ACTIVE.
        if (w_load) begin
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_cnt_d == c_SYNC_LAST) begin
            state_d = PTX_ACTIVE;
          end
        end
      end
      PTX_ACTIVE: begin
        if (valid_p) begin
          w_load_byte = data_p;
        end
      end
      default: begin
        state_d = PTX_SYNC;
      end
    endcase
  end

  ptx_shifter u_shifter (
    .clk_i  (clk_32f),
    .rst_ni (reset),
    .load_i (w_load),
    .byte_i (w_load_byte),
    .data_o (data_out)
  );

  assign tx_active = (state_q == PTX_ACTIVE);
  assign byte_req  = (state_q == PTX_ACTIVE) && w_load;

`ifdef PTX_COUNT_EN
  logic [15:0] byte_count_q;

  // byte_req marks exactly the ACTIVE load edges; wraps naturally at 16 bits.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      byte_count_q <= 16'h0000;
    end else if (byte_req && valid_p) begin
      byte_count_q <= byte_count_q + 16'h0001;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule : ptx_serializer
`default_nettype wire

// File: tb/tb_ptx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptx_serializer
// Description : Directed self-checking bench for ptx_serializer. Every edge
//               after reset release checks data_out, tx_active and byte_req
//               against hand-derived values for the default SYNC_BYTES=4.
// Build macro : PTX_COUNT_EN adds byte_count checks and the wrap test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptx_serializer;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic [7:0]  data_p  = 8'h00;
  logic        valid_p = 1'b0;
  logic        byte_req;
  logic        data_out;
  logic        tx_active;
`ifdef PTX_COUNT_EN
  logic [15:0] byte_count;
`endif

  int errors = 0;
  int checks = 0;
  int e      = 0;   // edge number since last reset release

  always #5 clk_32f = ~clk_32f;

  ptx_serializer dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_p     (data_p),
    .valid_p    (valid_p),
    .byte_req   (byte_req),
    .data_out   (data_out),
`ifdef PTX_COUNT_EN
    .byte_count (byte_count),
`endif
    .tx_active  (tx_active)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  // One edge; outputs sampled 1 time unit after it.
  task automatic tick_chk(input logic exp_bit);
    @(posedge clk_32f);
    #1;
    e++;
    chk("data_out", {15'd0, data_out}, {15'd0, exp_bit});
    chk("tx_active", {15'd0, tx_active}, {15'd0, (e >= 25)});
    chk("byte_req", {15'd0, byte_req}, {15'd0, ((e >= 32) && (e % 8 == 0))});
  endtask

  // One byte slot; the inputs for the next slot are applied right after this
  // slot's load edge, so they are stable across the next byte_req cycle.
  task automatic send_slot(input logic [7:0] exp_byte, input logic nv, input logic [7:0] nd);
    for (int i = 7; i >= 0; i--) begin
      tick_chk(exp_byte[i]);
      if (i == 7) begin
        valid_p = nv;
        data_p  = nd;
      end
    end
  endtask

  task automatic do_reset(input logic v, input logic [7:0] d);
    reset   = 1'b0;
    valid_p = v;
    data_p  = d;
    #1;
    chk("rst_data_out", {15'd0, data_out}, 16'd0);
    chk("rst_tx_active", {15'd0, tx_active}, 16'd0);
    chk("rst_byte_req", {15'd0, byte_req}, 16'd0);
`ifdef PTX_COUNT_EN
    chk("rst_byte_count", byte_count, 16'd0);
`endif
    @(negedge clk_32f);
    reset = 1'b1;
    e     = 0;
  endtask

  initial begin
    #2;
    // Run 1: idle only -> continuous BC stream, tx_active after edge 25.
    do_reset(1'b0, 8'h00);
    for (int s = 0; s < 5; s++) send_slot(8'hBC, 1'b0, 8'h00);

    // Run 2: A5 held valid from edge 1, ignored until edge 33.
    do_reset(1'b1, 8'hA5);
    for (int s = 0; s < 4; s++) send_slot(8'hBC, 1'b1, 8'hA5);
    send_slot(8'hA5, 1'b0, 8'h00);
    send_slot(8'hBC, 1'b0, 8'h00);

    // Run 3: back-to-back 00, FF, 3C at edges 33, 41, 49.
    do_reset(1'b0, 8'h00);
    for (int s = 0; s < 3; s++) send_slot(8'hBC, 1'b0, 8'h00);
    send_slot(8'hBC, 1'b1, 8'h00);
    send_slot(8'h00, 1'b1, 8'hFF);
    send_slot(8'hFF, 1'b1, 8'h3C);
    send_slot(8'h3C, 1'b0, 8'h00);
`ifdef PTX_COUNT_EN
    chk("count_b2b", byte_count, 16'd3);
`endif
    send_slot(8'hBC, 1'b0, 8'h00);

    // Run 4: valid 1/0/1 with 5A -> 5A, BC, 5A.
    do_reset(1'b0, 8'h00);
    for (int s = 0; s < 3; s++) send_slot(8'hBC, 1'b0, 8'h00);
    send_slot(8'hBC, 1'b1, 8'h5A);
    send_slot(8'h5A, 1'b0, 8'h5A);
    send_slot(8'hBC, 1'b1, 8'h5A);
    send_slot(8'h5A, 1'b0, 8'h00);
`ifdef PTX_COUNT_EN
    chk("count_alt", byte_count, 16'd2);
`endif

    // Run 5: reset mid-byte after edge 36 while data_out is 1.
    do_reset(1'b1, 8'h5A);
    for (int s = 0; s < 4; s++) send_slot(8'hBC, 1'b1, 8'h5A);
    tick_chk(1'b0);
    tick_chk(1'b1);
    tick_chk(1'b0);
    tick_chk(1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_data_out", {15'd0, data_out}, 16'd0);
    chk("mid_tx_active", {15'd0, tx_active}, 16'd0);
    chk("mid_byte_req", {15'd0, byte_req}, 16'd0);
`ifdef PTX_COUNT_EN
    chk("mid_byte_count", byte_count, 16'd0);
`endif
    @(negedge clk_32f);
    reset = 1'b1;
    e     = 0;
    for (int s = 0; s < 4; s++) send_slot(8'hBC, 1'b1, 8'h5A);
    send_slot(8'h5A, 1'b0, 8'h00);
`ifdef PTX_COUNT_EN
    chk("count_after_mid", byte_count, 16'd1);

    // Run 6: counter wrap from FFFF to 0.
    do_reset(1'b0, 8'h00);
    force dut.byte_count_q = 16'hFFFF;
    #1;
    release dut.byte_count_q;
    #1;
    chk("count_forced", byte_count, 16'hFFFF);
    for (int s = 0; s < 3; s++) send_slot(8'hBC, 1'b0, 8'h00);
    send_slot(8'hBC, 1'b1, 8'h77);
    send_slot(8'h77, 1'b0, 8'h00);
    chk("count_wrap", byte_count, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ptx_serializer
`default_nettype wire

// File: doc/ptx_serializer.md
# ptx_serializer

Parallel-to-serial lane transmitter: the transmit end of the byte-serial link the PPRX receiver decodes. It accepts one 8-bit byte with a valid flag every eight `clk_32f` cycles and shifts it out MSB first on a single serial line. It emits `BC` comma bytes when no data is valid, and after reset it sends a fixed run of commas so the far-end receiver can frame and raise `active`. It sits after the byte-striping logic and drives the serial lane directly.

## Interface
- `SYNC_BYTES`, default 4: number of comma bytes sent after reset before data is accepted (range 1–15).
- `COMMA`, default 8'hBC: idle/sync byte value.

Ports:
- `clk_32f`  in  1: bit clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low; one clock, no other clock domains.
- `data_p`  in  8: parallel byte to transmit.
- `valid_p`  in  1: `data_p` is valid. Sampled only at a load edge.
- `byte_req`  out  1: high for exactly the one cycle whose closing edge samples `data_p`/`valid_p`.
- `data_out`  out  1: serial bit, registered.
- `tx_active`  out  1: high once the sync run is complete.
- `byte_count`  out  16: number of valid bytes transmitted. Present only with `PTX_COUNT_EN`.

## Operation
- State machine with two states:
  - SYNC: the reset state.
  - ACTIVE: entered on the load edge of the last sync comma; stays until reset.
- Counters:
  - `bit_cnt`, 3 bits, increments every cycle and wraps 7→0.
  - A load edge is any rising edge with `bit_cnt==7`.
  - `sync_cnt`, 4 bits, counts commas loaded in SYNC.
- Load edge behaviour:
  - SYNC: load `COMMA` and ignore `valid_p`. `sync_cnt++`. When `sync_cnt` reaches `SYNC_BYTES`, go to ACTIVE.
  - ACTIVE with `valid_p=1`: load `data_p`.
  - ACTIVE with `valid_p=0`: load `COMMA`.
- Data path:
  - On a load edge: `data_out<=byte[7]` and `shreg<={byte[6:0],1'b0}`.
  - Every other edge: `data_out<=shreg[7]` and `shreg<=shreg<<1`.
- Flag decode from registers (no input path):
  - `byte_req = (state==ACTIVE) && (bit_cnt==7)`.
  - `tx_active = (state==ACTIVE)`.
- Reset values:
  - `state=SYNC`, `bit_cnt=7`, `sync_cnt=0`, `shreg=0`.
  - `data_out=0`, `byte_req=0`, `tx_active=0`, `byte_count=0`.
- Reset mid-byte: the partial byte is abandoned immediately. The full sync run restarts after release.
- `data_p`/`valid_p` changing between load edges: no effect.

## Timing
- Edges are numbered from 1, the first rising edge after `reset` deasserts. Edge 1 is a load edge, because `bit_cnt` resets to 7.
- Load edges fall at 1, 9, 17, … (every 8 edges).
- Default `SYNC_BYTES=4`:
  - Commas are loaded at edges 1, 9, 17, 25.
  - `tx_active` rises after edge 25.
  - `byte_req` is high between edges 32 and 33.
  - The first data sample is at edge 33.
- Latency: a byte sampled at edge N puts bit7 on `data_out` after edge N and bit0 after edge N+7. Bytes are back-to-back with no gap bits.
- Throughput: one byte per 8 cycles. There is no backpressure; the upstream must hold its byte valid across the `byte_req` cycle.

## Configuration
- `PTX_COUNT_EN` defined:
  - The `byte_count` port exists.
  - It increments at each ACTIVE load edge with `valid_p=1`.
  - It wraps from 16'hFFFF to 0 and resets to 0.
- `PTX_COUNT_EN` not defined: the port and its counter are absent. Serial behaviour is identical in both builds.

## Structure
- Shared package `ptx_pkg` holds:
  - the state enum (`PTX_SYNC`, `PTX_ACTIVE`);
  - the default `COMMA` constant 8'hBC;
  - the `bit_cnt` width constant.
- One sub-module, `ptx_shifter`: the 8-bit load/shift register and the `data_out` flop. It has `load` and `byte` inputs.
- The top level holds the FSM, the counters and the optional statistics counter.

## Test plan
- Reset release, `valid_p=0` throughout:
  - `data_out` repeats 1,0,1,1,1,1,0,0 continuously from edge 1.
  - `tx_active` rises after edge 25.
  - `byte_req` is high on the cycles before edges 33, 41, ….
- `valid_p=1`, `data_p=8'hA5` held from edge 1:
  - Only commas until edge 33 (the input is ignored in SYNC).
  - Then 1,0,1,0,0,1,0,1 appears after edges 33–40.
- Consecutive bytes 8'h00, 8'hFF, 8'h3C presented at edges 33, 41, 49:
  - Exactly 24 bits are sent with no gaps.
  - `byte_count=3` (count build).
- Alternating `valid_p` 1/0/1 with `data_p=8'h5A` at edges 33/41/49:
  - Output is 5A, BC, 5A.
  - `byte_count=2`.
- `reset` asserted asynchronously at edge 36 (mid-byte):
  - `data_out`, `tx_active` and `byte_count` go to 0 at once.
  - After release, 4 commas are sent before the next `byte_req`.
- Wrap: force `byte_count` to 16'hFFFF, then send one valid byte → `byte_count=0`.
